reg_file_cmd_ctrl: RTL and testbench



---
 rtl/reg_file_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/reg_file_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_reg_file_cmd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register-file command front-end.
// Holds FSM encoding and the command packing order {write, addr, data}.
package reg_file_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags.
// Head entry is presented combinationally on o_data.
module cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_cmd_ctrl.sv
// Command front-end: buffers commands, sequences register-file pins,
// and returns read data over a valid/ready response channel.
module reg_file_cmd_ctrl
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Write,
  input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [DATA_WIDTH-1:0] Cmd_WrData,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic [DATA_WIDTH-1:0] Rsp_Data,
  output logic [ADDR_WIDTH-1:0] Rsp_Addr
);

  localparam int CW = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic [CW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hd_write;
  logic [ADDR_WIDTH-1:0] w_hd_addr;
  logic [DATA_WIDTH-1:0] w_hd_data;

  state_t                r_state;
  state_t                w_nxt_state;
  logic                  r_wren;
  logic                  r_rden;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic                  w_nxt_wren;
  logic                  w_nxt_rden;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0] w_nxt_wdata;
  logic                  w_nxt_rsp_valid;
  logic [DATA_WIDTH-1:0] w_nxt_rsp_data;
  logic [ADDR_WIDTH-1:0] w_nxt_rsp_addr;

  assign Cmd_Ready  = !w_full && !RST;
  assign w_push     = Cmd_Valid && Cmd_Ready;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_hd_write = w_head[CW-1];
  assign w_hd_addr  = w_head[DATA_WIDTH +: ADDR_WIDTH];
  assign w_hd_data  = w_head[DATA_WIDTH-1:0];

  cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_data  ({Cmd_Write, Cmd_Addr, Cmd_WrData}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_wren      = 1'b0;
    w_nxt_rden      = 1'b0;
    w_nxt_addr      = r_addr;
    w_nxt_wdata     = r_wdata;
    w_nxt_rsp_valid = r_rsp_valid;
    w_nxt_rsp_data  = r_rsp_data;
    w_nxt_rsp_addr  = r_rsp_addr;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_nxt_addr = w_hd_addr;
          if (w_hd_write) begin
            w_nxt_wdata = w_hd_data;
            w_nxt_wren  = 1'b1;
            w_nxt_state = S_WRITE;
          end else begin
            w_nxt_rden  = 1'b1;
            w_nxt_state = S_READ;
          end
        end
      end
      S_WRITE: w_nxt_state = S_IDLE;
      S_READ:  w_nxt_state = S_CAPT;
      // Register file output is valid the cycle after RdEn
      S_CAPT: begin
        w_nxt_rsp_data  = RdData;
        w_nxt_rsp_addr  = r_addr;
        w_nxt_rsp_valid = 1'b1;
        w_nxt_state     = S_RESP;
      end
      S_RESP: begin
        if (Rsp_Ready) begin
          w_nxt_rsp_valid = 1'b0;
          w_nxt_state     = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_wren      <= 1'b0;
      r_rden      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_wren      <= w_nxt_wren;
      r_rden      <= w_nxt_rden;
      r_addr      <= w_nxt_addr;
      r_wdata     <= w_nxt_wdata;
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_data  <= w_nxt_rsp_data;
      r_rsp_addr  <= w_nxt_rsp_addr;
    end
  end

  assign WrEn      = r_wren;
  assign RdEn      = r_rden;
  assign Address   = r_addr;
  assign WrData    = r_wdata;
  assign Rsp_Valid = r_rsp_valid;
  assign Rsp_Data  = r_rsp_data;
  assign Rsp_Addr  = r_rsp_addr;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Scoreboard bench for reg_file_cmd_ctrl with an 8x16 register file stub.
// Expected responses come from an array model updated in command order.
module tb_reg_file_cmd_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Cmd_Valid;
  logic          Cmd_Ready;
  logic          Cmd_Write;
  logic [AW-1:0] Cmd_Addr;
  logic [DW-1:0] Cmd_WrData;
  logic          WrEn;
  logic          RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData = '0;
  logic          Rsp_Valid;
  logic          Rsp_Ready;
  logic [DW-1:0] Rsp_Data;
  logic [AW-1:0] Rsp_Addr;

  always #5 CLK = ~CLK;

  reg_file_cmd_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Write  (Cmd_Write),
    .Cmd_Addr   (Cmd_Addr),
    .Cmd_WrData (Cmd_WrData),
    .WrEn       (WrEn),
    .RdEn       (RdEn),
    .Address    (Address),
    .WrData     (WrData),
    .RdData     (RdData),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Data   (Rsp_Data),
    .Rsp_Addr   (Rsp_Addr)
  );

  // Register file stub: write and read both take effect at the edge
  logic [DW-1:0] rf [8] = '{default: '0};
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    if (RdEn) RdData <= rf[Address];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ad_t;

  ad_t           wq[$];
  ad_t           rspq[$];
  logic [AW-1:0] rq[$];
  logic [DW-1:0] model [8];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_cyc = 0;
  bit rnd_rr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  logic prev_wr, prev_rd, prev_rv, hold;
  ad_t  hd;

  always @(negedge CLK) begin
    if (RST) begin
      prev_wr = 1'b0;
      prev_rd = 1'b0;
      prev_rv = 1'b0;
      hold    = 1'b0;
    end else begin
      if (WrEn || RdEn) chk("wren_rden_overlap", 32'(WrEn && RdEn), 0);
      if (WrEn) begin
        chk("wren_pulse", 32'(prev_wr), 0);
        if (wq.size() == 0) chk("unexpected_wren", 1, 0);
        else begin
          hd = wq.pop_front();
          chk("wr_addr", 32'(Address), 32'(hd.a));
          chk("wr_data", 32'(WrData), 32'(hd.d));
        end
      end
      if (RdEn) begin
        chk("rden_pulse", 32'(prev_rd), 0);
        chk("rden_during_rsp", 32'(Rsp_Valid), 0);
        rd_cyc = cyc;
        if (rq.size() == 0) chk("unexpected_rden", 1, 0);
        else chk("rd_addr", 32'(Address), 32'(rq.pop_front()));
      end
      if (Rsp_Valid && !prev_rv) chk("rsp_latency", 32'(cyc - rd_cyc), 2);
      if (hold) chk("rsp_valid_held", 32'(Rsp_Valid), 1);
      if (Rsp_Valid) begin
        if (rspq.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          chk("rsp_data", 32'(Rsp_Data), 32'(rspq[0].d));
          chk("rsp_addr", 32'(Rsp_Addr), 32'(rspq[0].a));
          if (Rsp_Ready) void'(rspq.pop_front());
        end
      end
      hold    = Rsp_Valid && !Rsp_Ready;
      prev_wr = WrEn;
      prev_rd = RdEn;
      prev_rv = Rsp_Valid;
    end
  end

  // Entered and left at #1 after a rising edge
  task automatic send(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    bit acc = 1'b0;
    Cmd_Valid  = 1'b1;
    Cmd_Write  = wr;
    Cmd_Addr   = a;
    Cmd_WrData = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      if (rnd_rr) Rsp_Ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      acc = Cmd_Ready;
      @(posedge CLK);
      #1;
    end
    Cmd_Valid = 1'b0;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
    else if (wr) begin
      model[a] = d;
      wq.push_back('{a: a, d: d});
    end else begin
      rq.push_back(a);
      rspq.push_back('{a: a, d: model[a]});
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge CLK);
      done = (wq.size() == 0) && (rq.size() == 0) && (rspq.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;
    RST        = 1'b1;
    Cmd_Valid  = 1'b0;
    Cmd_Write  = 1'b0;
    Cmd_Addr   = '0;
    Cmd_WrData = '0;
    Rsp_Ready  = 1'b1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", 32'(Cmd_Ready), 0);
    chk("rst_wren", 32'(WrEn), 0);
    chk("rst_rden", 32'(RdEn), 0);
    chk("rst_address", 32'(Address), 0);
    chk("rst_wrdata", 32'(WrData), 0);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 0);
    chk("rst_rsp_data", 32'(Rsp_Data), 0);
    chk("rst_rsp_addr", 32'(Rsp_Addr), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_cmd_ready", 32'(Cmd_Ready), 1);
    chk("post_rst_wren", 32'(WrEn), 0);
    chk("post_rst_rden", 32'(RdEn), 0);
    @(posedge CLK);
    #1;

    send(1'b1, 3'd3, 16'hA5C3);
    send(1'b0, 3'd3, '0);
    drain();

    // Fill the FIFO behind a stalled response
    Rsp_Ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 3'(i), '0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("fifo_full_ready", 32'(Cmd_Ready), 0);
    @(posedge CLK);
    #1;
    fork
      send(1'b0, 3'd5, '0);
      begin
        repeat (8) @(posedge CLK);
        #1;
        Rsp_Ready = 1'b1;
      end
    join
    drain();

    Rsp_Ready = 1'b0;
    send(1'b0, 3'd2, '0);
    send(1'b0, 3'd4, '0);
    repeat (9) @(posedge CLK);
    #1;
    Rsp_Ready = 1'b1;
    drain();

    for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) send(1'b0, 3'(i), '0);
    drain();

    rnd_rr = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)),
           16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        Rsp_Ready = ($urandom_range(0, 3) != 0);
        @(posedge CLK);
        #1;
      end
    end
    rnd_rr    = 1'b0;
    Rsp_Ready = 1'b1;
    drain();

    // Reset while a read sits in CAPT with more reads queued behind it
    Rsp_Ready = 1'b0;
    send(1'b0, 3'd7, '0);
    send(1'b0, 3'd0, '0);
    send(1'b0, 3'd1, '0);
    send(1'b0, 3'd2, '0);
    Rsp_Ready = 1'b1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge CLK);
        seen = RdEn && (Address == 3'd0);
      end
      if (!seen) chk("mid_rst_rden_timeout", 0, 1);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    rq.delete();
    rspq.delete();
    wq.delete();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("mid_rst_no_rsp", 32'(Rsp_Valid), 0);
      chk("mid_rst_no_rden", 32'(RdEn), 0);
    end
    @(posedge CLK);
    #1;
    send(1'b0, 3'd0, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
